// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit SRAM controller: access sizes,
// FSM states, the default acknowledge-timeout and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] LSU_WORD = 2'b00;
    localparam logic [1:0] LSU_RSVD = 2'b01;
    localparam logic [1:0] LSU_HALF = 2'b10;
    localparam logic [1:0] LSU_BYTE = 2'b11;

    localparam int unsigned LSU_TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Bytes never misalign; the reserved size behaves like a word.
    function automatic logic lsu_misaligned(input logic [1:0] op, input logic [1:0] lo);
        logic mis;
        case (op)
            LSU_BYTE: mis = 1'b0;
            LSU_HALF: mis = lo[0];
            default:  mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_ld_extract.sv
// Load-data lane select and sign/zero extension for the LSU SRAM controller.
module lsu_ld_extract
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  op_i,
    input  logic        ld_un_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sign_s;

    // Pick the addressed lane, then extend it to 32 bits.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        sign_s = 1'b0;
        data_o = rdata_i;
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (op_i)
            LSU_BYTE: begin
                sign_s = ~ld_un_i & byte_s[7];
                data_o = {{24{sign_s}}, byte_s};
            end
            LSU_HALF: begin
                sign_s = ~ld_un_i & half_s[15];
                data_o = {{16{sign_s}}, half_s};
            end
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Load/store unit to single-port SRAM controller (IDLE -> REQ -> DONE).
// Optional acknowledge timeout is compiled in with macro LSU_TIMEOUT_EN.
module lsu_sram_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = LSU_TIMEOUT_CYC_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_rd,
    input  logic        i_mem_wren,
    input  logic [1:0]  i_lsu_op,
    input  logic        i_ld_un,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_timeout,
    output logic        o_sram_req,
    output logic        o_sram_we,
    output logic [31:0] o_sram_addr,
    output logic [31:0] o_sram_wdata,
    output logic [3:0]  o_sram_bmask,
    input  logic [31:0] i_sram_rdata,
    input  logic        i_sram_ack
);

    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  bmask_q, bmask_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic        ld_un_q, ld_un_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        misalign_q, misalign_d;

    logic        access_s;
    logic        misalign_s;
    logic        start_s;
    logic [3:0]  bmask_s;
    logic [31:0] wdata_s;
    logic [31:0] ext_s;

    assign access_s   = i_mem_rd | i_mem_wren;
    assign misalign_s = access_s & lsu_misaligned(i_lsu_op, i_addr[1:0]);
    assign start_s    = (state_q == ST_IDLE) & access_s & ~misalign_s;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic             timeout_q, timeout_d;
    assign cnt_inc_s = cnt_q + CNT_W'(1);
    assign o_timeout = timeout_q;
`else
    logic timeout_cfg_unused_s;
    assign timeout_cfg_unused_s = (TIMEOUT_CYC == 0);
    assign o_timeout = 1'b0;
`endif

    lsu_ld_extract u_ld_extract (
        .rdata_i   (i_sram_rdata),
        .addr_lo_i (lo_q),
        .op_i      (op_q),
        .ld_un_i   (ld_un_q),
        .data_o    (ext_s)
    );

    // Store lane steering; loads read the whole word with no write data.
    always_comb begin
        bmask_s = 4'b1111;
        wdata_s = i_st_data;
        case (i_lsu_op)
            LSU_BYTE: begin
                bmask_s = 4'b0001 << i_addr[1:0];
                wdata_s = {4{i_st_data[7:0]}};
            end
            LSU_HALF: begin
                bmask_s = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{i_st_data[15:0]}};
            end
            default: begin
                bmask_s = 4'b1111;
                wdata_s = i_st_data;
            end
        endcase
        if (!i_mem_wren) begin
            bmask_s = 4'b1111;
            wdata_s = 32'h0000_0000;
        end else begin
            bmask_s = bmask_s;
        end
    end

    // Next-state and datapath capture for the access FSM.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bmask_d    = bmask_q;
        op_d       = op_q;
        lo_d       = lo_q;
        ld_un_d    = ld_un_q;
        ld_data_d  = 32'h0000_0000;
        misalign_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = i_mem_wren;
                    addr_d  = {i_addr[31:2], 2'b00};
                    wdata_d = wdata_s;
                    bmask_d = bmask_s;
                    op_d    = i_lsu_op;
                    lo_d    = i_addr[1:0];
                    ld_un_d = i_ld_un;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    misalign_d = misalign_s;
                end
            end
            ST_REQ: begin
                if (i_sram_ack) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    ld_data_d = we_q ? 32'h0000_0000 : ext_s;
                end else begin
`ifdef LSU_TIMEOUT_EN
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CNT_W'(TIMEOUT_CYC)) begin
                        state_d   = ST_DONE;
                        req_d     = 1'b0;
                        we_d      = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and registered SRAM-side outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            bmask_q    <= 4'b0000;
            op_q       <= 2'b00;
            lo_q       <= 2'b00;
            ld_un_q    <= 1'b0;
            ld_data_q  <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bmask_q    <= bmask_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            ld_un_q    <= ld_un_d;
            ld_data_q  <= ld_data_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Acknowledge wait counter and its one-cycle expiry flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    // Stall rises in the accepting IDLE cycle so the pipeline holds at once.
    assign o_stall      = start_s | (state_q == ST_REQ);
    assign o_sram_req   = req_q;
    assign o_sram_we    = we_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_sram_bmask = bmask_q;
    assign o_ld_data    = ld_data_q;
    assign o_misalign   = misalign_q;

endmodule

// File: doc/lsu_sram_ctrl.md
LSU_SRAM_CTRL -- requirements
Module: lsu_sram_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum wait cycles for an acknowledge when the timeout feature is compiled in.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port i_clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port i_mem_rd, input, 1 bit: current instruction is a load.
REQ-006 Port i_mem_wren, input, 1 bit: current instruction is a store.
REQ-007 Port i_lsu_op, input, 2 bits: access size; 00 word, 10 half, 11 byte, 01 reserved (treated as word).
REQ-008 Port i_ld_un, input, 1 bit: load zero-extends when 1 and sign-extends when 0.
REQ-009 Port i_addr, input, 32 bits: byte address from the ALU.
REQ-010 Port i_st_data, input, 32 bits: rs2 store data.
REQ-011 Port o_ld_data, output, 32 bits: extended load result for write-back.
REQ-012 Port o_stall, output, 1 bit: PC/regfile hold request.
REQ-013 Port o_misalign, output, 1 bit: one-cycle misaligned-access pulse.
REQ-014 Port o_timeout, output, 1 bit: one-cycle acknowledge-timeout pulse.
REQ-015 Port o_sram_req, output, 1 bit: SRAM request.
REQ-016 Port o_sram_we, output, 1 bit: SRAM write enable.
REQ-017 Port o_sram_addr, output, 32 bits: word-aligned SRAM address, with bits [1:0] = 00.
REQ-018 Port o_sram_wdata, output, 32 bits: SRAM write data.
REQ-019 Port o_sram_bmask, output, 4 bits: SRAM byte enables.
REQ-020 Port i_sram_rdata, input, 32 bits: SRAM read data.
REQ-021 Port i_sram_ack, input, 1 bit: SRAM completion.

Function
REQ-022 The FSM SHALL have states IDLE, REQ and DONE.
REQ-023 In IDLE, when i_mem_rd or i_mem_wren is set with an aligned address, the block SHALL assert o_stall combinationally, register address, data, mask, we, op and ld_un, and move to REQ.
REQ-024 i_mem_rd and i_mem_wren set together SHALL be treated as a store.
REQ-025 In REQ, the block SHALL hold o_sram_req=1 with stable address, data, mask and we, and keep o_stall=1.
REQ-026 In REQ, on i_sram_ack the block SHALL capture i_sram_rdata and move to DONE; an acknowledge in the same cycle the request rises SHALL be accepted.
REQ-027 In DONE, the block SHALL drive o_stall=0, o_sram_req=0 and a valid o_ld_data, then return to IDLE unconditionally.
REQ-028 A new access SHALL be accepted only from IDLE.
REQ-029 The minimum access SHALL be 3 cycles (IDLE, REQ, DONE), with exactly 2 stalled cycles.
REQ-030 Misaligned accesses are a half access with addr[0]=1, or a word access with addr[1:0]!=00.
REQ-031 On a misaligned access, the block SHALL issue no SRAM request, pulse o_misalign for 1 cycle, hold o_stall=0 and o_ld_data=0, suppress any store, and stay in IDLE.
REQ-032 Store byte SHALL drive o_sram_bmask = 0001 shifted left by addr[1:0], with wdata equal to the byte replicated 4 times.
REQ-033 Store half SHALL drive o_sram_bmask = 0011 when addr[1]=0 and 1100 when addr[1]=1, with wdata equal to the half replicated twice.
REQ-034 Store word SHALL drive o_sram_bmask = 1111.
REQ-035 A load SHALL select the byte or half by the registered addr[1:0], then extend it per ld_un; a word load SHALL pass through unchanged.
REQ-036 A load SHALL drive o_sram_we=0 and o_sram_bmask=1111.
REQ-037 o_ld_data SHALL be 0 whenever the state is not DONE.
REQ-038 An i_sram_ack outside REQ SHALL be ignored.

Reset
REQ-039 Asserting i_rst_n=0 SHALL immediately force IDLE and drive o_sram_req, o_sram_we, o_stall, o_misalign and o_timeout to 0.
REQ-040 Asserting i_rst_n=0 SHALL immediately drive o_sram_addr, o_sram_wdata, o_sram_bmask, o_ld_data and the timeout counter to 0.
REQ-041 A reset during REQ SHALL abandon the access; no completion SHALL occur after deassertion.

Configuration
REQ-042 Macro LSU_TIMEOUT_EN defined: a counter SHALL clear on entry to REQ and increment each REQ cycle without acknowledge.
REQ-043 With LSU_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC the block SHALL drop o_sram_req, pulse o_timeout for 1 cycle, and enter DONE with o_ld_data=0.
REQ-044 With LSU_TIMEOUT_EN defined, an acknowledge in the same cycle as the timeout SHALL win.
REQ-045 Macro LSU_TIMEOUT_EN undefined: REQ SHALL wait indefinitely, no counter SHALL exist, and o_timeout SHALL be tied to 0.

Structure
REQ-046 Package lsu_pkg SHALL hold the lsu_op encodings (LSU_WORD, LSU_HALF, LSU_BYTE), the FSM state enum and the default TIMEOUT_CYC constant.
REQ-047 Sub-module lsu_ld_extract SHALL hold the combinational byte/half select and sign/zero extend, instantiated once.

Verification
REQ-048 Scenario, lb signed: addr 0x1003, rdata 0x80FF_1234 with ack after 2 REQ cycles -> o_ld_data 0xFFFF_FF80, o_stall high 3 cycles.
REQ-049 Scenario, lhu: addr 0x2002, rdata 0xBEEF_0000, immediate ack -> o_ld_data 0x0000_BEEF, 2 stall cycles.
REQ-050 Scenario, sb: addr 0x0101, st_data 0x0000_00A5 -> o_sram_bmask 0010, o_sram_wdata 0xA5A5_A5A5, o_sram_addr 0x0100, o_sram_we 1.
REQ-051 Scenario, lw misaligned: addr 0x0006 -> o_misalign pulse, o_sram_req never asserted, o_stall 0.
REQ-052 Scenario, reset mid-REQ: i_rst_n low in REQ -> o_sram_req 0 immediately, IDLE after release, a late ack ignored.
REQ-053 Scenario, LSU_TIMEOUT_EN with TIMEOUT_CYC=4 and no ack -> o_timeout pulse after 4 REQ cycles, o_ld_data 0, return to IDLE.
